waveform_generator: RTL and testbench

//  Parametrised multi-mode waveform generator: triangle, sawtooth-up, sawtooth-down and square.

---
 rtl/waveform_generator_if.sv | 27 ++
 rtl/waveform_generator.sv | 153 +++++++++++++++
 tb/tb_waveform_generator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_generator_if.sv
// Control/config/status bundle for waveform_generator.
// The master drives load/ena and the config fields; the slave returns the waveform outputs.
interface waveform_generator_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned STEP_W = 4
);
    logic              ena;
    logic              load;
    logic [1:0]        mode_in;
    logic [N-1:0]      lo_in;
    logic [N-1:0]      hi_in;
    logic [STEP_W-1:0] step_in;
    logic [N-1:0]      out;
    logic              dir;
    logic              period;
    logic              cfg_err;

    modport master (
        output ena, load, mode_in, lo_in, hi_in, step_in,
        input  out, dir, period, cfg_err
    );

    modport slave (
        input  ena, load, mode_in, lo_in, hi_in, step_in,
        output out, dir, period, cfg_err
    );
endinterface

// File: rtl/waveform_generator.sv
// Multi-mode waveform generator (triangle, saw up/down, square) with run-time bounds and step.
// Values are clamped to [lo,hi]; all outputs are registered.
module waveform_generator #(
    parameter int unsigned N      = 8,
    parameter int unsigned STEP_W = 4
) (
    input logic                clk,
    input logic                rst,
    waveform_generator_if.slave bus
);
    localparam logic [1:0] MODE_TRI    = 2'b00;
    localparam logic [1:0] MODE_SAW_UP = 2'b01;
    localparam logic [1:0] MODE_SAW_DN = 2'b10;
    localparam logic [1:0] MODE_SQUARE = 2'b11;

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    logic [1:0]        mode_q, mode_d;
    logic [N-1:0]      lo_q, lo_d;
    logic [N-1:0]      hi_q, hi_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] sq_cnt_q, sq_cnt_d;
    logic [N-1:0]      out_q, out_d;
    logic              dir_q, dir_d;
    logic              period_q, period_d;
    logic              cfg_err_q, cfg_err_d;

    // Sums in N+1 bits so bound tests never see a modulo-2^N wrap.
    logic [N:0]        step_ext;
    logic [N:0]        out_ext;
    logic [N:0]        hi_ext;
    logic [N:0]        up_sum;
    logic [N:0]        lo_sum;
    logic [N-1:0]      down_val;
    logic [STEP_W-1:0] step_last;

    assign step_ext  = {{(N + 1 - STEP_W){1'b0}}, step_q};
    assign out_ext   = {1'b0, out_q};
    assign hi_ext    = {1'b0, hi_q};
    assign up_sum    = out_ext + step_ext;
    assign lo_sum    = {1'b0, lo_q} + step_ext;
    assign down_val  = out_q - step_ext[N-1:0];
    assign step_last = step_q - STEP_ONE;

    always_comb begin
        mode_d    = mode_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        step_d    = step_q;
        sq_cnt_d  = sq_cnt_q;
        out_d     = out_q;
        dir_d     = dir_q;
        period_d  = 1'b0;
        cfg_err_d = cfg_err_q;

        if (bus.load) begin
            if (bus.lo_in < bus.hi_in) begin
                mode_d    = bus.mode_in;
                lo_d      = bus.lo_in;
                hi_d      = bus.hi_in;
                step_d    = (bus.step_in == '0) ? STEP_ONE : bus.step_in;
                out_d     = (bus.mode_in == MODE_SAW_DN) ? bus.hi_in : bus.lo_in;
                dir_d     = (bus.mode_in == MODE_SAW_DN);
                sq_cnt_d  = '0;
                cfg_err_d = 1'b0;
            end else begin
                // Rejected load also suppresses this cycle's advance.
                cfg_err_d = 1'b1;
            end
        end else if (bus.ena) begin
            unique case (mode_q)
                MODE_TRI: begin
                    if (!dir_q) begin
                        if (up_sum >= hi_ext) begin
                            out_d = hi_q;
                            dir_d = 1'b1;
                        end else begin
                            out_d = up_sum[N-1:0];
                        end
                    end else if (out_ext <= lo_sum) begin
                        out_d    = lo_q;
                        dir_d    = 1'b0;
                        period_d = 1'b1;
                    end else begin
                        out_d = down_val;
                    end
                end
                MODE_SAW_UP: begin
                    if (out_q == hi_q) begin
                        out_d    = lo_q;
                        period_d = 1'b1;
                    end else if (up_sum > hi_ext) begin
                        out_d = hi_q;
                    end else begin
                        out_d = up_sum[N-1:0];
                    end
                end
                MODE_SAW_DN: begin
                    if (out_q == lo_q) begin
                        out_d    = hi_q;
                        period_d = 1'b1;
                    end else if (out_ext < lo_sum) begin
                        out_d = lo_q;
                    end else begin
                        out_d = down_val;
                    end
                end
                MODE_SQUARE: begin
                    if (sq_cnt_q == step_last) begin
                        sq_cnt_d = '0;
                        if (out_q == lo_q) begin
                            out_d    = hi_q;
                            period_d = 1'b1;
                        end else begin
                            out_d = lo_q;
                        end
                    end else begin
                        sq_cnt_d = sq_cnt_q + STEP_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_TRI;
            lo_q      <= '0;
            hi_q      <= '1;
            step_q    <= STEP_ONE;
            sq_cnt_q  <= '0;
            out_q     <= '0;
            dir_q     <= 1'b0;
            period_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            step_q    <= step_d;
            sq_cnt_q  <= sq_cnt_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            period_q  <= period_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.dir     = dir_q;
    assign bus.period  = period_q;
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_waveform_generator.sv
// Randomised self-checking bench for waveform_generator.
// The model precomputes one full period of each programmed waveform as a list of states.
module tb_waveform_generator;
    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    waveform_generator_if #(.N(N), .STEP_W(STEP_W)) bus ();

    waveform_generator #(.N(N), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // One period of the waveform: value, dir, and whether arriving there pulses period.
    int cyc_out[$];
    bit cyc_dir[$];
    bit cyc_pf[$];
    int m_idx;
    bit m_per;
    bit m_err;

    function automatic void push(int v, bit d, bit p);
        cyc_out.push_back(v);
        cyc_dir.push_back(d);
        cyc_pf.push_back(p);
    endfunction

    function automatic void build(int mode, int lo, int hi, int st);
        int x;
        cyc_out.delete();
        cyc_dir.delete();
        cyc_pf.delete();
        case (mode)
            0: begin
                push(lo, 1'b0, 1'b1);
                x = lo;
                while (x + st < hi) begin x += st; push(x, 1'b0, 1'b0); end
                push(hi, 1'b1, 1'b0);
                x = hi;
                while (x - st > lo) begin x -= st; push(x, 1'b1, 1'b0); end
            end
            1: begin
                push(lo, 1'b0, 1'b1);
                x = lo;
                while (x != hi) begin x = (x + st > hi) ? hi : x + st; push(x, 1'b0, 1'b0); end
            end
            2: begin
                push(hi, 1'b1, 1'b1);
                x = hi;
                while (x != lo) begin x = (x < lo + st) ? lo : x - st; push(x, 1'b1, 1'b0); end
            end
            default: begin
                for (int i = 0; i < 2 * st; i++) push((i < st) ? lo : hi, 1'b0, i == st);
            end
        endcase
        m_idx = 0;
    endfunction

    function automatic void model_reset();
        build(0, 0, 255, 1);
        m_per = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic logic [10:0] exp_vec();
        return {8'(cyc_out[m_idx]), cyc_dir[m_idx], m_per, m_err};
    endfunction

    function automatic logic [10:0] act_vec();
        return {bus.out, bus.dir, bus.period, bus.cfg_err};
    endfunction

    // Apply one cycle of stimulus, advance the model, and leave time at posedge+1.
    task automatic drive(bit e, bit l, int mode, int lo, int hi, int st);
        bus.ena     = e;
        bus.load    = l;
        bus.mode_in = mode[1:0];
        bus.lo_in   = lo[7:0];
        bus.hi_in   = hi[7:0];
        bus.step_in = st[3:0];
        @(posedge clk);
        if (l) begin
            if (lo < hi) begin
                build(mode, lo, hi, (st == 0) ? 1 : st);
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_per = 1'b0;
        end else if (e) begin
            m_idx = (m_idx + 1) % cyc_out.size();
            m_per = cyc_pf[m_idx];
        end else begin
            m_per = 1'b0;
        end
        #1;
    endtask

    task automatic drive_junk(bit e);
        drive(e, 1'b0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 15));
    endtask

    task automatic test_reset();
        bus.ena = 1'b0; bus.load = 1'b0; bus.mode_in = '0;
        bus.lo_in = '0; bus.hi_in = '0; bus.step_in = '0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (act_vec() !== 11'd0)
            $display("FAIL test_reset immediate: got %h want %h", act_vec(), 11'd0);
        if (act_vec() !== 11'd0) miscompares++;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (act_vec() !== 11'd0) begin
            miscompares++;
            $display("FAIL test_reset held: got %h want %h", act_vec(), 11'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_triangle();
        int last = -1;
        for (int i = 1; i <= 1030; i++) begin
            drive_junk(1'b1);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_triangle cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (bus.period) begin
                if (last >= 0) begin
                    vectors++;
                    if (i - last !== 510) begin
                        miscompares++;
                        $display("FAIL full_triangle period spacing: got %0d want 510", i - last);
                    end
                end
                last = i;
            end
        end
        vectors++;
        if (last != 1020) begin
            miscompares++;
            $display("FAIL full_triangle last period: got %0d want 1020", last);
        end
    endtask

    task automatic test_triangle_small();
        int seq[10] = '{10, 13, 16, 19, 20, 17, 14, 11, 10, 13};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 0, 10, 20, 3);
            else drive_junk(1'b1);
            vectors++;
            if (act_vec() !== exp_vec() || int'(bus.out) != seq[i]
                || bus.period !== (i == 8)) begin
                miscompares++;
                $display("FAIL triangle_small step %0d: got %h (out %0d) want %h (out %0d)",
                         i, act_vec(), bus.out, exp_vec(), seq[i]);
            end
        end
    endtask

    task automatic test_saw();
        int up[7] = '{0, 2, 4, 6, 7, 0, 2};
        int dn[6] = '{7, 5, 3, 1, 0, 7};
        for (int i = 0; i < 13; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 1, 0, 7, 2);
            else if (i == 7) drive(1'b1, 1'b1, 2, 0, 7, 2);
            else drive_junk(1'b1);
            vectors++;
            if (act_vec() !== exp_vec() || int'(bus.out) != ((i < 7) ? up[i] : dn[i - 7])
                || bus.period !== (i == 5 || i == 12)) begin
                miscompares++;
                $display("FAIL saw step %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_square();
        int seen_hi = 0;
        drive(1'b1, 1'b1, 3, 5, 200, 3);
        for (int i = 0; i < 30; i++) begin
            drive_junk(i % 2 == 0);
            vectors++;
            if (act_vec() !== exp_vec() || (bus.out !== 8'd5 && bus.out !== 8'd200)) begin
                miscompares++;
                $display("FAIL square cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (bus.out == 8'd200) seen_hi++;
        end
        vectors++;
        if (seen_hi == 0) begin
            miscompares++;
            $display("FAIL square never reached hi: got %0d want >0", seen_hi);
        end
    endtask

    task automatic test_cfg_err();
        drive(1'b1, 1'b1, 0, 40, 90, 4);
        for (int i = 0; i < 14; i++) begin
            if (i == 2) drive(1'b1, 1'b1, 1, 30, 30, 5);
            else if (i == 9) drive(1'b1, 1'b1, 0, 0, 100, 0);
            else drive_junk(1'b1);
            vectors++;
            if (act_vec() !== exp_vec() || bus.cfg_err !== (i >= 2 && i < 9)) begin
                miscompares++;
                $display("FAIL cfg_err step %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
                drive($urandom_range(0, 1), 1'b1, $urandom_range(0, 3), $urandom_range(0, 254),
                      $urandom_range(0, 255), $urandom_range(0, 15));
            else
                drive_junk($urandom_range(0, 3) != 0);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 0, 0, 255, 5);
        repeat (60) drive_junk(1'b1);
        vectors++;
        if (act_vec() !== exp_vec() || bus.dir !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset pre (falling): got %h want %h", act_vec(), exp_vec());
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.out !== 8'd0 || bus.dir !== 1'b0 || bus.period !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset immediate: got %h want %h", act_vec(), 11'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_junk(1'b1);
            vectors++;
            if (act_vec() !== exp_vec() || int'(bus.out) != i + 1) begin
                miscompares++;
                $display("FAIL async_reset restart %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_triangle();
        test_triangle_small();
        test_saw();
        test_square();
        test_cfg_err();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
